// File: rtl/wb_tgen_pkg.sv
// Shared types and constants for the Wishbone SDRAM traffic generator.
package wb_tgen_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWaitInit,
        StWr,
        StWrGap,
        StRd,
        StRdGap,
        StFin
    } tgen_state_e;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

    localparam logic [1:0] MODE_WR   = 2'd0;
    localparam logic [1:0] MODE_RD   = 2'd1;
    localparam logic [1:0] MODE_WRRD = 2'd2;
    localparam logic [1:0] MODE_RSVD = 2'd3;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
    endfunction

endpackage

// File: rtl/wb_tgen_pattern.sv
// Data pattern source for the traffic generator; `TGEN_LFSR_EN selects a Galois LFSR,
// otherwise the word is the byte address XOR seed.
module wb_tgen_pattern
    import wb_tgen_pkg::*;
#(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 26
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          load,
    input  logic          advance,
    input  logic [31:0]   seed,
    input  logic [AW-1:0] addr,
    output logic [DW-1:0] data
);

`ifdef TGEN_LFSR_EN
    logic [31:0] lfsr_q;
    logic        unused_addr;

    assign unused_addr = ^addr;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q <= 32'd1;
        end else if (load) begin
            // An all-zero state would lock the LFSR.
            lfsr_q <= (seed == 32'd0) ? 32'd1 : seed;
        end else if (advance) begin
            lfsr_q <= lfsr_next(lfsr_q);
        end
    end

    assign data = lfsr_q[DW-1:0];
`else
    logic [31:0] seed_q;
    logic [31:0] mix;
    logic        unused_advance;

    assign unused_advance = advance;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            seed_q <= 32'd0;
        end else if (load) begin
            seed_q <= seed;
        end
    end

    assign mix  = 32'(addr) ^ seed_q;
    assign data = mix[DW-1:0];
`endif

endmodule

// File: rtl/wb_sdram_tgen.sv
// Self-checking Wishbone burst traffic generator for the SDRAM controller slave port.
// Pattern source selected by `TGEN_LFSR_EN inside wb_tgen_pattern.
module wb_sdram_tgen
    import wb_tgen_pkg::*;
#(
    parameter int unsigned DW     = 32,
    parameter int unsigned AW     = 26,
    parameter int unsigned LW     = 16,
    parameter int unsigned BL_MAX = 8
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_i,
    input  logic                       sdr_init_done,
    input  logic                       start,
    input  logic [1:0]                 mode,
    input  logic [AW-1:0]              base_addr,
    input  logic [LW-1:0]              num_words,
    input  logic [$clog2(BL_MAX):0]    burst_len,
    input  logic [31:0]                seed,
    output logic                       busy,
    output logic                       done,
    output logic [15:0]                err_cnt,
    output logic [AW-1:0]              first_err_addr,
    output logic                       wb_cyc_o,
    output logic                       wb_stb_o,
    output logic                       wb_we_o,
    output logic [AW-1:0]              wb_addr_o,
    output logic [DW-1:0]              wb_dat_o,
    output logic [DW/8-1:0]            wb_sel_o,
    output logic [2:0]                 wb_cti_o,
    input  logic                       wb_ack_i,
    input  logic [DW-1:0]              wb_dat_i
);

    localparam int unsigned   BLW        = $clog2(BL_MAX) + 1;
    localparam logic [AW-1:0] STEP       = AW'(DW / 8);
    localparam logic [AW-1:0] ALIGN_MASK = ~AW'(DW / 8 - 1);

    tgen_state_e    state_q;
    logic [1:0]     mode_q;
    logic [AW-1:0]  base_q;
    logic [LW-1:0]  nwords_q;
    logic [BLW-1:0] bl_q;
    logic [31:0]    seed_q;
    logic [AW-1:0]  addr_q;        // address of the next beat to issue
    logic [LW-1:0]  words_left_q;  // words of this phase not yet issued
    logic [BLW-1:0] beats_left_q;  // beats of this burst incl. the one on the bus
    logic           last_q;        // phase exhausted at the end of the last burst
    logic [DW-1:0]  exp_q;

    logic           has_write, has_read;
    logic [BLW-1:0] bl_in, burst_n;
    logic           ack_beat, more, burst_end;
    logic           start_burst, issue, issue_wr, reload, mismatch;
    logic           pat_load;
    logic [31:0]    pat_seed;
    logic [DW-1:0]  pat_data;

    assign has_write = (mode_q != MODE_WR + MODE_RD) ? 1'b1 : 1'b0;
    assign has_read  = (mode_q != MODE_WR);

    always_comb begin
        bl_in = burst_len;
        if (burst_len == '0) begin
            bl_in = BLW'(1);
        end else if (burst_len > BLW'(BL_MAX)) begin
            bl_in = BLW'(BL_MAX);
        end
    end

    assign burst_n   = (words_left_q < LW'(bl_q)) ? BLW'(words_left_q) : bl_q;
    assign ack_beat  = wb_stb_o && wb_ack_i && (state_q == StWr || state_q == StRd);
    assign more      = beats_left_q > BLW'(1);
    assign burst_end = ack_beat && !more;

    assign start_burst = (state_q == StWaitInit && sdr_init_done && words_left_q != '0) ||
                         (state_q == StWrGap && (!last_q || has_read)) ||
                         (state_q == StRdGap && !last_q);
    assign issue    = start_burst || (ack_beat && more);
    assign issue_wr = (state_q == StWaitInit && has_write) ||
                      (state_q == StWrGap && !last_q) || (state_q == StWr);

    // Rewind for the read pass on the final write ack so RD can start right after the gap.
    assign reload   = burst_end && state_q == StWr && words_left_q == '0 && has_read;
    assign mismatch = ack_beat && state_q == StRd && (wb_dat_i != exp_q);
    assign pat_load = (state_q == StIdle && start) || reload;
    assign pat_seed = (state_q == StIdle) ? seed : seed_q;

    wb_tgen_pattern #(
        .DW (DW),
        .AW (AW)
    ) u_pattern (
        .clk_i   (wb_clk_i),
        .rst_ni  (wb_rst_i),
        .load    (pat_load),
        .advance (issue),
        .seed    (pat_seed),
        .addr    (addr_q),
        .data    (pat_data)
    );

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state_q        <= StIdle;
            mode_q         <= MODE_WR;
            base_q         <= '0;
            nwords_q       <= '0;
            bl_q           <= BLW'(1);
            seed_q         <= '0;
            addr_q         <= '0;
            words_left_q   <= '0;
            beats_left_q   <= '0;
            last_q         <= 1'b0;
            exp_q          <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            err_cnt        <= '0;
            first_err_addr <= '0;
            wb_cyc_o       <= 1'b0;
            wb_stb_o       <= 1'b0;
            wb_we_o        <= 1'b0;
            wb_addr_o      <= '0;
            wb_dat_o       <= '0;
            wb_sel_o       <= '0;
            wb_cti_o       <= CTI_CLASSIC;
        end else begin
            done <= 1'b0;

            if (issue) begin
                wb_cyc_o     <= 1'b1;
                wb_stb_o     <= 1'b1;
                wb_we_o      <= issue_wr;
                wb_addr_o    <= addr_q;
                wb_dat_o     <= issue_wr ? pat_data : '0;
                wb_sel_o     <= '1;
                exp_q        <= pat_data;
                addr_q       <= addr_q + STEP;
                words_left_q <= words_left_q - LW'(1);
                if (start_burst) begin
                    beats_left_q <= burst_n;
                    wb_cti_o     <= (burst_n == BLW'(1)) ? CTI_EOB : CTI_INCR;
                end else begin
                    beats_left_q <= beats_left_q - BLW'(1);
                    wb_cti_o     <= (beats_left_q == BLW'(2)) ? CTI_EOB : CTI_INCR;
                end
            end else if (burst_end) begin
                wb_cyc_o <= 1'b0;
                wb_stb_o <= 1'b0;
                wb_we_o  <= 1'b0;
                wb_sel_o <= '0;
                wb_cti_o <= CTI_CLASSIC;
                last_q   <= (words_left_q == '0);
            end

            if (reload) begin
                addr_q       <= base_q;
                words_left_q <= nwords_q;
            end

            if (mismatch) begin
                if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
                if (err_cnt == 16'd0) first_err_addr <= wb_addr_o;
            end

            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        mode_q         <= mode;
                        base_q         <= base_addr & ALIGN_MASK;
                        nwords_q       <= num_words;
                        bl_q           <= bl_in;
                        seed_q         <= seed;
                        addr_q         <= base_addr & ALIGN_MASK;
                        words_left_q   <= num_words;
                        err_cnt        <= '0;
                        first_err_addr <= '0;
                        busy           <= 1'b1;
                        state_q        <= StWaitInit;
                    end
                end
                StWaitInit: begin
                    if (sdr_init_done) begin
                        if (words_left_q == '0) begin
                            state_q <= StFin;
                            done    <= 1'b1;
                            busy    <= 1'b0;
                        end else begin
                            state_q <= has_write ? StWr : StRd;
                        end
                    end
                end
                StWr: if (burst_end) state_q <= StWrGap;
                StWrGap: begin
                    if (!last_q) begin
                        state_q <= StWr;
                    end else if (has_read) begin
                        state_q <= StRd;
                    end else begin
                        state_q <= StFin;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                    end
                end
                StRd: if (burst_end) state_q <= StRdGap;
                StRdGap: begin
                    if (!last_q) begin
                        state_q <= StRd;
                    end else begin
                        state_q <= StFin;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                    end
                end
                StFin: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
